// File: rtl/vector_pkg.sv
// Shared types and default sizes for the vector execute stage.
//   op_e    : lane operation encodings
//   state_e : sequencer states
package vector_pkg;

  localparam int unsigned DEF_WIDTH           = 24;
  localparam int unsigned DEF_VECTOR_WIDTH    = 8;
  localparam int unsigned DEF_LANES_PER_CYCLE = 2;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_XOR  = 3'b101,
    OP_SLL  = 3'b110,
    OP_SADD = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

endpackage

// File: rtl/vector_alu_seq_if.sv
// Instruction/result bundle between the vector execute stage and its neighbours.
//   in_valid/in_ready   : instruction handshake, op/a/b carried with it
//   out_valid/out_ready : result handshake, res carried with it
//   busy                : stage is executing or holding a result
// master = upstream/downstream side, slave = execute stage.
interface vector_alu_seq_if
  import vector_pkg::*;
#(
  parameter int unsigned WIDTH        = DEF_WIDTH,
  parameter int unsigned VECTOR_WIDTH = DEF_VECTOR_WIDTH
) ();

  logic                               in_valid;
  logic                               in_ready;
  op_e                                op;
  logic [VECTOR_WIDTH-1:0][WIDTH-1:0] a;
  logic [VECTOR_WIDTH-1:0][WIDTH-1:0] b;
  logic                               out_valid;
  logic                               out_ready;
  logic [VECTOR_WIDTH-1:0][WIDTH-1:0] res;
  logic                               busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, res, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, res, busy
  );

endinterface

// File: rtl/vector_lane_alu.sv
// Combinational single-lane ALU.
//   op_i : operation
//   a_i  : lane operand A
//   b_i  : lane operand B (shift amount for SLL)
//   y_c  : lane result, WIDTH bits
module vector_lane_alu
  import vector_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  op_e              op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_c
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  logic [WIDTH-1:0] sum_c;
  logic             sadd_ovf_c;

  // Signed overflow: operands share a sign that the sum does not.
  always_comb begin
    sum_c      = a_i + b_i;
    sadd_ovf_c = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_c[WIDTH-1] != a_i[WIDTH-1]);
  end

  always_comb begin
    y_c = '0;
    case (op_i)
      OP_ADD: y_c = sum_c;
      OP_SUB: y_c = a_i - b_i;
      OP_MUL: y_c = a_i * b_i;
      OP_AND: y_c = a_i & b_i;
      OP_OR:  y_c = a_i | b_i;
      OP_XOR: y_c = a_i ^ b_i;
      OP_SLL: begin
        // Out-of-range shifts flush to zero rather than wrapping the shift field.
        if (b_i >= WIDTH'(WIDTH)) y_c = '0;
        else                      y_c = a_i << b_i[SH_W-1:0];
      end
      OP_SADD: begin
        if (!sadd_ovf_c)       y_c = sum_c;
        else if (a_i[WIDTH-1]) y_c = {1'b1, {(WIDTH-1){1'b0}}};
        else                   y_c = {1'b0, {(WIDTH-1){1'b1}}};
      end
      default: y_c = '0;
    endcase
  end

endmodule

// File: rtl/vector_alu_seq.sv
// Multi-cycle vector execute stage: accepts one instruction, computes
// LANES_PER_CYCLE lanes per clock into a result buffer, then holds the full
// result until the downstream register takes it.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : slave side of vector_alu_seq_if (instruction in, result out, busy)
module vector_alu_seq
  import vector_pkg::*;
#(
  parameter int unsigned WIDTH           = DEF_WIDTH,
  parameter int unsigned VECTOR_WIDTH    = DEF_VECTOR_WIDTH,
  parameter int unsigned LANES_PER_CYCLE = DEF_LANES_PER_CYCLE
) (
  input logic              clk,
  input logic              reset,
  vector_alu_seq_if.slave  bus
);

  localparam int unsigned IDX_W    = (VECTOR_WIDTH > 1) ? $clog2(VECTOR_WIDTH) : 1;
  localparam int unsigned LAST_GRP = VECTOR_WIDTH - LANES_PER_CYCLE;

  if (LANES_PER_CYCLE == 0 || (VECTOR_WIDTH % LANES_PER_CYCLE) != 0) begin : g_bad_lanes
    $error("vector_alu_seq: LANES_PER_CYCLE must divide VECTOR_WIDTH");
  end

  state_e                             state_q, state_d;
  logic                               in_ready_q, in_ready_d;
  logic                               out_valid_q, out_valid_d;
  logic                               busy_q, busy_d;
  op_e                                op_q;
  logic [VECTOR_WIDTH-1:0][WIDTH-1:0] a_q, b_q, res_q;
  logic [IDX_W-1:0]                   cnt_q;

  logic                               accept_c;
  logic                               last_grp_c;
  logic [IDX_W-1:0]                   lane_idx_c [LANES_PER_CYCLE];
  logic [WIDTH-1:0]                   lane_y_c   [LANES_PER_CYCLE];

  assign accept_c   = (state_q == ST_IDLE) && bus.in_valid;
  assign last_grp_c = (cnt_q == IDX_W'(LAST_GRP));

  // One lane ALU per slot, each picking its lane out of the latched operands.
  for (genvar k = 0; k < LANES_PER_CYCLE; k++) begin : g_lane
    assign lane_idx_c[k] = cnt_q + IDX_W'(k);

    vector_lane_alu #(.WIDTH(WIDTH)) u_lane_alu (
      .op_i (op_q),
      .a_i  (a_q[lane_idx_c[k]]),
      .b_i  (b_q[lane_idx_c[k]]),
      .y_c  (lane_y_c[k])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.in_valid)  state_d = ST_EXEC;
      ST_EXEC: if (last_grp_c)    state_d = ST_HOLD;
      ST_HOLD: if (bus.out_ready) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the status flags can be registered.
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    case (state_d)
      ST_IDLE: in_ready_d = 1'b1;
      ST_EXEC: busy_d     = 1'b1;
      ST_HOLD: begin
        out_valid_d = 1'b1;
        busy_d      = 1'b1;
      end
      default: in_ready_d = 1'b1;
    endcase
  end

  // Status flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Operand capture, lane counter and result buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q  <= OP_ADD;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      cnt_q <= '0;
    end else begin
      if (accept_c) begin
        op_q  <= bus.op;
        a_q   <= bus.a;
        b_q   <= bus.b;
        cnt_q <= '0;
      end
      if (state_q == ST_EXEC) begin
        for (int k = 0; k < int'(LANES_PER_CYCLE); k++) begin
          res_q[lane_idx_c[k]] <= lane_y_c[k];
        end
        cnt_q <= cnt_q + IDX_W'(LANES_PER_CYCLE);
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.res       = res_q;

endmodule

// File: doc/vector_alu_seq.md
Name: vector_alu_seq

Overview:
Multi-cycle vector execute stage. Accepts one vector instruction (op plus two VECTOR_WIDTH x WIDTH operand vectors) over a valid/ready handshake. Processes LANES_PER_CYCLE lanes per clock and presents the full result vector to the downstream vector pipeline register. out_valid && out_ready drives that register's enable.

Parameters:
WIDTH, 24, bits per lane element
VECTOR_WIDTH, 8, lanes per vector
LANES_PER_CYCLE, 2, lanes computed per EXEC cycle; must divide VECTOR_WIDTH (elaboration-time assertion)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept an instruction
op  in  3  operation code, sampled on accept
a  in  [VECTOR_WIDTH][WIDTH]  operand vector A, lane i = a[i]
b  in  [VECTOR_WIDTH][WIDTH]  operand vector B, lane i = b[i]
out_valid  out  1  res holds a complete result
out_ready  in  1  downstream consumes result
res  out  [VECTOR_WIDTH][WIDTH]  result vector, lane i = res[i]
busy  out  1  high in EXEC or HOLD

Behaviour:
- Reset (synchronous, active-high) returns state to IDLE. Outputs: in_ready=1, out_valid=0, busy=0, res=0, lane counter=0. Reset aborts any EXEC or HOLD in progress; the partial result is discarded.
- FSM states: IDLE, EXEC, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid: latch op, a and b into internal operand registers, clear lane counter, go to EXEC.
- EXEC:
  - in_ready=0. Input ports are ignored; latched copies are used.
  - Each cycle computes lanes [cnt, cnt+LANES_PER_CYCLE-1] and writes them into the result buffer. Then cnt += LANES_PER_CYCLE.
  - The cycle that writes the last group transitions to HOLD.
- HOLD:
  - out_valid=1. res is stable.
  - When out_ready=1: transfer completes, go to IDLE. out_valid=0 and in_ready=1 next cycle. No same-cycle re-accept.
  - When out_ready=0: stay in HOLD indefinitely.
- Latency: accept on edge T gives out_valid=1 after edge T+VECTOR_WIDTH/LANES_PER_CYCLE (4 cycles at defaults). Throughput is one instruction per (VECTOR_WIDTH/LANES_PER_CYCLE + 2) cycles minimum.
- res is driven directly from the result buffer. It holds the previous result outside HOLD and is only meaningful while out_valid=1. Lanes not yet written in EXEC keep old values.
- Lane ops, all WIDTH-bit:
  - 000 ADD: a+b modulo 2^WIDTH.
  - 001 SUB: a-b modulo 2^WIDTH.
  - 010 MUL: low WIDTH bits of the unsigned product.
  - 011 AND.
  - 100 OR.
  - 101 XOR.
  - 110 SLL: a << b[4:0] when WIDTH=24; shift field is $clog2(WIDTH) bits. Any b value >= WIDTH yields 0.
  - 111 SADD: signed two's-complement add, saturating to 2^(WIDTH-1)-1 on positive overflow and -2^(WIDTH-1) on negative overflow.
- Simultaneous events: reset dominates in_valid and out_ready. in_valid is ignored outside IDLE.

Decomposition:
- Package vector_pkg holds: the op encodings as typedef enum logic [2:0] (OP_ADD..OP_SADD), the FSM state enum, and the default WIDTH and VECTOR_WIDTH constants.
- One sub-module, vector_lane_alu: purely combinational single-lane ALU (op, a, b -> y, WIDTH parameter). It is instantiated LANES_PER_CYCLE times and fed by a mux indexed by the lane counter.

Test Plan:
- ADD wrap and lane ordering: a[i]=i, b[i]=10*i, except a[7]=0xFFFFFF, b[7]=1 -> res[i]=11*i for i<7, res[7]=0x000000. out_valid exactly 4 cycles after accept.
- SADD saturation:
  - 0x7FFFFF+0x000001 -> 0x7FFFFF
  - 0x800000+0xFFFFFF -> 0x800000
  - 0x000005+0xFFFFFE -> 0x000003
- SLL/MUL:
  - SLL of 0x000001 by 4 -> 0x000010
  - SLL by 24 -> 0x000000
  - MUL 0x001000*0x001000 -> 0x000000
  - MUL 0x000123*0x000010 -> 0x001230
- Backpressure: hold out_ready=0 for 5 cycles in HOLD -> res, out_valid=1 and in_ready=0 all stable. Operand inputs changed mid-EXEC do not affect res. out_ready=1 gives in_ready=1 on the next cycle.
- Reset mid-EXEC (after 2 EXEC cycles) -> next cycle in_ready=1, out_valid=0, res=0. A following ADD completes normally with correct values.
- Back-to-back: in_valid held high with two instructions -> second accepted exactly 1 cycle after the first transfer. Both results are correct and delivered in order.
